// File: rtl/hilo_muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit and the control unit that drives it.
// Holds the op codes, FSM state encoding, iteration count and a magnitude helper.
package hilo_muldiv_pkg;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int ITER = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULT   = 2'd1,
    DIV    = 2'd2,
    FINISH = 2'd3
  } state_e;

  // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned 2^31.
  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// Request/result bundle between the control unit (master) and the HI/LO unit (slave).
interface hilo_muldiv_if;
  logic        start;
  logic        op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        done;
  logic        div_zero;

  modport master (
    output start, op, a_in, b_in,
    input  hi_out, lo_out, busy, done, div_zero
  );

  modport slave (
    input  start, op, a_in, b_in,
    output hi_out, lo_out, busy, done, div_zero
  );
endinterface

// File: rtl/hilo_muldiv.sv
// Iterative signed MULT (radix-2 Booth) / DIV (restoring on magnitudes) producing HI and LO.
// Both datapaths share one working register and one iteration counter.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int ITER = hilo_muldiv_pkg::ITER
) (
  input  logic          clk,
  input  logic          reset,
  hilo_muldiv_if.slave  bus
);

  localparam logic [5:0] LAST = 6'(ITER - 1);

  state_e      state, state_n;
  logic [5:0]  cnt, cnt_n;
  // Working register {hi33, lo32, q-1}: hi carries a guard bit so subtracting
  // a multiplicand of 0x80000000 cannot overflow; in DIV hi33 holds the partial remainder.
  logic [65:0] p, p_n;
  logic [31:0] m, m_n;
  logic        op_r, op_n;
  logic        neg_q, neg_q_n, neg_r, neg_r_n;
  logic [31:0] hi, hi_n, lo, lo_n;
  logic        busy_r, busy_n, done_r, done_n, dz_r, dz_n;

  logic [32:0] booth_hi;
  logic [32:0] shifted;
  logic [33:0] diff;
  logic        qbit;
  logic [32:0] rem;
  logic [31:0] quot, rmag;

  always_comb begin
    booth_hi = p[65:33];
    unique case (p[1:0])
      2'b01:   booth_hi = p[65:33] + {m[31], m};
      2'b10:   booth_hi = p[65:33] - {m[31], m};
      default: booth_hi = p[65:33];
    endcase

    shifted = {p[64:33], p[32]};
    diff    = {1'b0, shifted} - {2'b00, m};
    qbit    = ~diff[33];
    rem     = qbit ? diff[32:0] : shifted;

    quot = p[32:1];
    rmag = p[64:33];
  end

  // NOTE: every variable gets its hold/default value first so no path leaves it unassigned (no latch).
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    p_n     = p;
    m_n     = m;
    op_n    = op_r;
    neg_q_n = neg_q;
    neg_r_n = neg_r;
    hi_n    = hi;
    lo_n    = lo;
    done_n  = 1'b0;
    dz_n    = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.op == OP_DIV && bus.b_in == 32'd0) begin
            dz_n = 1'b1;
          end else begin
            cnt_n   = 6'd0;
            op_n    = bus.op;
            neg_q_n = bus.a_in[31] ^ bus.b_in[31];
            neg_r_n = bus.a_in[31];
            if (bus.op == OP_MULT) begin
              state_n = MULT;
              m_n     = bus.a_in;
              p_n     = {33'd0, bus.b_in, 1'b0};
            end else begin
              state_n = DIV;
              m_n     = abs32(bus.b_in);
              p_n     = {33'd0, abs32(bus.a_in), 1'b0};
            end
          end
        end
      end

      MULT, DIV: begin
        if (state == MULT) p_n = {booth_hi[32], booth_hi, p[32:1]};
        else               p_n = {rem, p[31:1], qbit, 1'b0};
        if (cnt == LAST) state_n = FINISH;
        else             cnt_n   = cnt + 6'd1;
      end

      FINISH: begin
        state_n = IDLE;
        done_n  = 1'b1;
        if (op_r == OP_MULT) begin
          {hi_n, lo_n} = p[64:1];
        end else begin
          lo_n = neg_q ? (~quot + 32'd1) : quot;
          hi_n = neg_r ? (~rmag + 32'd1) : rmag;
        end
      end

      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      p      <= '0;
      m      <= '0;
      op_r   <= OP_MULT;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      p      <= p_n;
      m      <= m_n;
      op_r   <= op_n;
      neg_q  <= neg_q_n;
      neg_r  <= neg_r_n;
      hi     <= hi_n;
      lo     <= lo_n;
      busy_r <= busy_n;
      done_r <= done_n;
      dz_r   <= dz_n;
    end
  end

  assign bus.hi_out   = hi;
  assign bus.lo_out   = lo;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.div_zero = dz_r;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed vector table, multi-cycle corner sequences,
// and random operations checked against a plain-arithmetic reference model.
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  hilo_muldiv_if bus ();

  hilo_muldiv #(.ITER(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: signed 64-bit product, or C-style truncating quotient and dividend-signed remainder.
  function automatic logic [63:0] model(input logic op, input logic [31:0] a, input logic [31:0] b);
    longint la, lb, q, r, prod;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    if (op == OP_MULT) begin
      prod = la * lb;
      return prod;
    end
    q = la / lb;
    r = la % lb;
    return {r[31:0], q[31:0]};
  endfunction

  // Called at a negedge; returns at the negedge right after the sampling edge E0.
  task automatic launch(input logic op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a_in  = a;
    bus.b_in  = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bcnt, output bit ok);
    lat = 0; bcnt = 0; ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      if (bus.busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int lat, bcnt;
    bit ok;
    launch(op, a, b);
    wait_done(lat, bcnt, ok);
    check({name, " done seen"}, 64'(ok), 64'd1);
    check({name, " latency"}, 64'(lat), 64'd33);
    check({name, " busy cycles"}, 64'(bcnt), 64'd33);
    check({name, " hi"}, 64'(bus.hi_out), 64'(ehi));
    check({name, " lo"}, 64'(bus.lo_out), 64'(elo));
    check({name, " busy low with done"}, 64'(bus.busy), 64'd0);
    @(negedge clk);
    check({name, " done one cycle"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    logic [31:0] corners[6];
    logic [63:0] exp;
    logic [31:0] ra, rb;
    logic        rop;
    int lat, bcnt, nbusy, ndone, ndz;
    bit ok;

    vecs[0] = '{"mult 7x-3",        OP_MULT, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1] = '{"mult min x min",   OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[2] = '{"mult -1x-1",       OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[3] = '{"mult max x min",   OP_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000};
    vecs[4] = '{"div -7/2",         OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[5] = '{"div 7/-2",         OP_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[6] = '{"div 100/7",        OP_DIV,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    vecs[7] = '{"div 3/5",          OP_DIV,  32'h0000_0003, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000};
    vecs[8] = '{"div min/-1",       OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};

    bus.start = 1'b0; bus.op = OP_MULT; bus.a_in = '0; bus.b_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset hi", 64'(bus.hi_out), 64'd0);
    check("reset lo", 64'(bus.lo_out), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset div_zero", 64'(bus.div_zero), 64'd0);

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // Divide by zero right after min/-1: pulse only, HI/LO keep 0 / 0x80000000.
    launch(OP_DIV, 32'd5, 32'd0);
    check("dz pulse", 64'(bus.div_zero), 64'd1);
    check("dz busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    check("dz pulse width", 64'(bus.div_zero), 64'd0);
    nbusy = 0; ndone = 0; ndz = 0;
    for (int i = 0; i < 40; i++) begin
      nbusy += int'(bus.busy); ndone += int'(bus.done); ndz += int'(bus.div_zero);
      @(negedge clk);
    end
    check("dz no busy", 64'(nbusy), 64'd0);
    check("dz no done", 64'(ndone), 64'd0);
    check("dz no repeat", 64'(ndz), 64'd0);
    check("dz hi kept", 64'(bus.hi_out), 64'd0);
    check("dz lo kept", 64'(bus.lo_out), 64'h8000_0000);

    // Start while busy is ignored; a start during the done cycle is accepted.
    launch(OP_MULT, 32'd3, 32'd4);
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIV; bus.a_in = 32'd9; bus.b_in = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, bcnt, ok);
    check("ignore done seen", 64'(ok), 64'd1);
    check("ignore latency", 64'(lat + 5), 64'd33);
    check("ignore hi", 64'(bus.hi_out), 64'd0);
    check("ignore lo", 64'(bus.lo_out), 64'd12);
    launch(OP_MULT, 32'd5, 32'd6);
    check("restart busy", 64'(bus.busy), 64'd1);
    wait_done(lat, bcnt, ok);
    check("restart done seen", 64'(ok), 64'd1);
    check("restart latency", 64'(lat), 64'd33);
    check("restart lo", 64'(bus.lo_out), 64'd30);
    @(negedge clk);

    // Reset mid-operation clears everything at once and no done follows.
    launch(OP_MULT, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort hi", 64'(bus.hi_out), 64'd0);
    check("abort lo", 64'(bus.lo_out), 64'd0);
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort done", 64'(bus.done), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    ndone = 0; nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      ndone += int'(bus.done); nbusy += int'(bus.busy);
      @(negedge clk);
    end
    check("abort no done", 64'(ndone), 64'd0);
    check("abort no busy", 64'(nbusy), 64'd0);
    run_op("mult 2x2 after abort", OP_MULT, 32'd2, 32'd2, 32'd0, 32'd4);

    corners = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF,
                32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0002};
    for (int i = 0; i < 24; i++) begin
      rop = 1'($urandom_range(0, 1));
      ra  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      if (rop == OP_DIV && rb == 32'd0) rb = 32'd1;
      exp = model(rop, ra, rb);
      run_op($sformatf("rand%0d %s %h %h", i, rop ? "div" : "mult", ra, rb),
             rop, ra, rb, exp[63:32], exp[31:0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
